// File: rtl/spiker_adapter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : spiker_adapter_pkg                                            |
// | Description : Shared definitions for the spiker adapter (reader/writer).   |
// |               Holds the default frame geometry, the reader state encoding  |
// |               and a small ceiling-division helper.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spiker_adapter_pkg;

   // Default frame geometry shared by spiker_reader and spiker_writer.
   localparam int unsigned c_WIDTH    = 32;
   localparam int unsigned c_N_SPIKES = 784;
   localparam int unsigned c_N_STEPS  = 15;

   // Number of register words needed to hold a spike vector.
   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

   localparam int unsigned c_N_REG = ceil_div(c_N_SPIKES, c_WIDTH);

   // Reader sequencing: collect words, offer the frame, wait for the step to finish.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } reader_state_e;

endpackage
`default_nettype wire

// File: rtl/spiker_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spiker_frame_buffer                                           |
// | Description : N_REG x WIDTH word store for one input spike frame, with a   |
// |               per-word loaded mask and a flattened N_SPIKES-bit view.      |
// | Ports       : clk_i/rst_i   clock, synchronous active-high reset           |
// |               clear_i       wipe words and mask                            |
// |               clr_mask_i    wipe mask only (words retained)                |
// |               wr_en_i/wr_idx_i/wr_data_i  pre-qualified word write         |
// |               all_loaded_o  every word written since last mask clear       |
// |               spikes_o      flattened words, bit j of word i = spike i*W+j |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spiker_frame_buffer
   import spiker_adapter_pkg::*;
#(
   parameter int unsigned WIDTH    = c_WIDTH,
   parameter int unsigned N_SPIKES = c_N_SPIKES,
   parameter int unsigned N_REG    = c_N_REG,
   parameter int unsigned IDX_W    = $clog2(N_REG)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clear_i,
   input  logic                clr_mask_i,
   input  logic                wr_en_i,
   input  logic [IDX_W-1:0]    wr_idx_i,
   input  logic [WIDTH-1:0]    wr_data_i,
   output logic                all_loaded_o,
   output logic [N_SPIKES-1:0] spikes_o
);

   // Number of meaningful bits in the final (partial) word.
   localparam int unsigned c_LAST_BITS = N_SPIKES - (N_REG - 1) * WIDTH;

   logic [WIDTH-1:0] r_buf [N_REG];
   logic [N_REG-1:0] r_mask;

   // wr_idx_i is guaranteed in range by the caller.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         for (int i = 0; i < int'(N_REG); i++) begin
            r_buf[i] <= '0;
         end
         r_mask <= '0;
      end else begin
         if (clr_mask_i) begin
            r_mask <= '0;
         end
         if (wr_en_i) begin
            r_buf[wr_idx_i]  <= wr_data_i;
            r_mask[wr_idx_i] <= 1'b1;
         end
      end
   end

   assign all_loaded_o = &r_mask;

   for (genvar g = 0; g < int'(N_REG) - 1; g++) begin : g_word
      assign spikes_o[g*WIDTH +: WIDTH] = r_buf[g];
   end

   assign spikes_o[N_SPIKES-1 -: c_LAST_BITS] = r_buf[N_REG-1][c_LAST_BITS-1:0];

   // Upper bits of the last word are kept in storage but never reach the core.
   if (c_LAST_BITS < WIDTH) begin : g_pad
      logic w_unused_pad;
      assign w_unused_pad = ^r_buf[N_REG-1][WIDTH-1:c_LAST_BITS];
   end

endmodule
`default_nettype wire

// File: rtl/spiker_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spiker_reader                                                 |
// | Description : Input stage of the spiker adapter. Collects the spike frame  |
// |               word by word, then offers it to the SNN core once per        |
// |               timestep (valid/ready), advancing on the core's done.        |
// | Ports       : clk_i, rst_i          clock, synchronous active-high reset   |
// |               test_mode_i           reserved, unused                       |
// |               wr_en_i/idx/data      register-file word writes              |
// |               start_i, clear_i      frame start / abort pulses             |
// |               spikes_o, valid_o, ready_i  frame offer to the core          |
// |               done_i                core finished current timestep         |
// |               busy_o, step_o        status                                 |
// |               frame_done_o          pulse after last timestep              |
// |               err_o                 sticky protocol error                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spiker_reader
   import spiker_adapter_pkg::*;
#(
   parameter int unsigned WIDTH    = c_WIDTH,
   parameter int unsigned N_SPIKES = c_N_SPIKES,
   parameter int unsigned N_REG    = c_N_REG,
   parameter int unsigned N_STEPS  = c_N_STEPS,
   parameter int unsigned IDX_W    = $clog2(N_REG)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                test_mode_i,
   input  logic                wr_en_i,
   input  logic [IDX_W-1:0]    wr_idx_i,
   input  logic [WIDTH-1:0]    wr_data_i,
   input  logic                start_i,
   input  logic                clear_i,
   output logic [N_SPIKES-1:0] spikes_o,
   output logic                valid_o,
   input  logic                ready_i,
   input  logic                done_i,
   output logic                busy_o,
   output logic [3:0]          step_o,
   output logic                frame_done_o,
   output logic                err_o
);

   // Compare the index one bit wider so a power-of-two N_REG still works.
   localparam logic [IDX_W:0] c_N_REG_EXT = (IDX_W + 1)'(N_REG);
   localparam logic [3:0]     c_LAST_STEP = 4'(N_STEPS - 1);

   reader_state_e r_state;
   reader_state_e w_state_nx;
   logic [3:0]    r_step;
   logic [3:0]    w_step_nx;
   logic          r_frame_done;
   logic          r_err;

   logic          w_idle;
   logic          w_idx_ok;
   logic          w_buf_wr;
   logic          w_all_loaded;
   logic          w_frame_end;
   logic          w_start_err;
   logic          w_err_set;
   logic          w_unused_test_mode;

   assign w_unused_test_mode = test_mode_i;

   assign w_idle   = (r_state == ST_IDLE);
   assign w_idx_ok = ({1'b0, wr_idx_i} < c_N_REG_EXT);
   assign w_buf_wr = wr_en_i && w_idx_ok && w_idle;

   spiker_frame_buffer #(
      .WIDTH    (WIDTH),
      .N_SPIKES (N_SPIKES),
      .N_REG    (N_REG),
      .IDX_W    (IDX_W)
   ) u_frame_buffer (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clear_i      (clear_i),
      .clr_mask_i   (w_frame_end),
      .wr_en_i      (w_buf_wr),
      .wr_idx_i     (wr_idx_i),
      .wr_data_i    (wr_data_i),
      .all_loaded_o (w_all_loaded),
      .spikes_o     (spikes_o)
   );

   // w_all_loaded reflects the mask at the start of the cycle, so a write that
   // completes the mask cannot qualify a start in the same cycle.
   always_comb begin
      w_state_nx  = r_state;
      w_step_nx   = r_step;
      w_frame_end = 1'b0;
      w_start_err = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               if (w_all_loaded) begin
                  w_state_nx = ST_ISSUE;
                  w_step_nx  = '0;
               end else begin
                  w_start_err = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            if (ready_i) begin
               w_state_nx = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (done_i) begin
               if (r_step == c_LAST_STEP) begin
                  w_state_nx  = ST_IDLE;
                  w_frame_end = 1'b1;
               end else begin
                  w_state_nx = ST_ISSUE;
                  w_step_nx  = r_step + 4'd1;
               end
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   assign w_err_set = (wr_en_i && (!w_idle || !w_idx_ok))
                    || (start_i && !w_idle)
                    || w_start_err;

   // clear_i takes priority over every other input in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_state      <= ST_IDLE;
         r_step       <= '0;
         r_frame_done <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_step       <= w_step_nx;
         r_frame_done <= w_frame_end;
         r_err        <= r_err | w_err_set;
      end
   end

   assign valid_o      = (r_state == ST_ISSUE);
   assign busy_o       = !w_idle;
   assign step_o       = r_step;
   assign frame_done_o = r_frame_done;
   assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spiker_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spiker_reader                                              |
// | Description : Self-checking bench for spiker_reader. Stimulus updates a    |
// |               word-array reference model and queues the expected frame     |
// |               offers; a negedge monitor pops them on every handshake and   |
// |               on every frame_done pulse.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spiker_reader;
   import spiker_adapter_pkg::*;

   localparam int WIDTH    = 32;
   localparam int N_SPIKES = 784;
   localparam int N_REG    = 25;
   localparam int N_STEPS  = 15;
   localparam int IDX_W    = 5;

   typedef logic [N_SPIKES-1:0] vec_t;
   typedef struct {
      vec_t       sp;
      logic [3:0] st;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst_i;
   logic                test_mode_i;
   logic                wr_en_i;
   logic [IDX_W-1:0]    wr_idx_i;
   logic [WIDTH-1:0]    wr_data_i;
   logic                start_i;
   logic                clear_i;
   logic [N_SPIKES-1:0] spikes_o;
   logic                valid_o;
   logic                ready_i;
   logic                done_i;
   logic                busy_o;
   logic [3:0]          step_o;
   logic                frame_done_o;
   logic                err_o;

   always #5 clk = ~clk;

   spiker_reader #(
      .WIDTH    (WIDTH),
      .N_SPIKES (N_SPIKES),
      .N_REG    (N_REG),
      .N_STEPS  (N_STEPS),
      .IDX_W    (IDX_W)
   ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .test_mode_i  (test_mode_i),
      .wr_en_i      (wr_en_i),
      .wr_idx_i     (wr_idx_i),
      .wr_data_i    (wr_data_i),
      .start_i      (start_i),
      .clear_i      (clear_i),
      .spikes_o     (spikes_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .done_i       (done_i),
      .busy_o       (busy_o),
      .step_o       (step_o),
      .frame_done_o (frame_done_o),
      .err_o        (err_o)
   );

   // Reference model: the frame as an array of words plus loaded flags.
   logic [WIDTH-1:0] m_buf [N_REG];
   logic [N_REG-1:0] m_mask;
   bit               m_idle;
   bit               m_err;

   exp_t exp_q[$];
   int   fd_q[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input vec_t act, input vec_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Spike k lives in word k/WIDTH at bit k%WIDTH; bits past N_SPIKES are dropped.
   function automatic vec_t model_spikes();
      vec_t v;
      for (int k = 0; k < N_SPIKES; k++) begin
         v[k] = m_buf[k / WIDTH][k % WIDTH];
      end
      return v;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   bit   prev_busy = 1'b0;
   vec_t prev_spikes;

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_i) begin
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL hs_unexpected: got handshake step %0d expected none", step_o);
            end else begin
               e = exp_q.pop_front();
               chk("hs_spikes", spikes_o, e.sp);
               chk("hs_step", vec_t'(step_o), vec_t'(e.st));
            end
         end
         if (frame_done_o) begin
            if (fd_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL fd_unexpected: got frame_done 1 expected 0");
            end else begin
               void'(fd_q.pop_front());
            end
         end
         if (busy_o && prev_busy) begin
            chk("busy_stable", spikes_o, prev_spikes);
         end
         prev_busy   = busy_o;
         prev_spikes = spikes_o;
      end else begin
         prev_busy = 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic op(input bit we, input int idx, input logic [WIDTH-1:0] d, input bit st);
      bit   accept;
      bit   was_idle;
      exp_t e;
      accept   = 1'b0;
      was_idle = m_idle;
      if (st) begin
         if (m_idle && (m_mask == '1)) accept = 1'b1;
         else m_err = 1'b1;
      end
      if (we) begin
         if (m_idle && idx < N_REG) begin
            m_buf[idx]  = d;
            m_mask[idx] = 1'b1;
         end else begin
            m_err = 1'b1;
         end
      end
      test_mode_i = 1'($urandom_range(0, 1));
      wr_en_i     = we;
      wr_idx_i    = IDX_W'(idx);
      wr_data_i   = d;
      start_i     = st;
      @(posedge clk);
      #1;
      wr_en_i = 1'b0;
      start_i = 1'b0;
      if (accept) begin
         m_idle = 1'b0;
         e.sp   = model_spikes();
         for (int s = 0; s < N_STEPS; s++) begin
            e.st = 4'(s);
            exp_q.push_back(e);
         end
         fd_q.push_back(1);
      end
      chk("err", vec_t'(err_o), vec_t'(m_err));
      if (st && was_idle) chk("start_valid", vec_t'(valid_o), vec_t'(accept));
   endtask

   task automatic idle_cycle();
      op(1'b0, 0, '0, 1'b0);
   endtask

   task automatic reload(input bit skip_last);
      int top;
      top = skip_last ? N_REG - 1 : N_REG;
      for (int i = 0; i < top; i++) op(1'b1, i, $urandom, 1'b0);
      repeat (3) op(1'b1, $urandom_range(0, top - 1), $urandom, 1'b0);
   endtask

   // clear_i collides with a write and a start; clear must win.
   task automatic do_clear();
      ready_i   = 1'b0;
      done_i    = 1'b0;
      clear_i   = 1'b1;
      wr_en_i   = 1'b1;
      wr_idx_i  = '0;
      wr_data_i = $urandom;
      start_i   = 1'b1;
      @(posedge clk);
      #1;
      clear_i = 1'b0;
      wr_en_i = 1'b0;
      start_i = 1'b0;
      exp_q.delete();
      fd_q.delete();
      m_idle = 1'b1;
      m_mask = '0;
      m_err  = 1'b0;
      for (int i = 0; i < N_REG; i++) m_buf[i] = '0;
      chk("clr_busy", vec_t'(busy_o), '0);
      chk("clr_valid", vec_t'(valid_o), '0);
      chk("clr_step", vec_t'(step_o), '0);
      chk("clr_spikes", spikes_o, '0);
      chk("clr_err", vec_t'(err_o), '0);
      chk("clr_fd", vec_t'(frame_done_o), '0);
   endtask

   // mode 0: ready already high, done the cycle after each handshake.
   task automatic run_frame(input int mode, input int bp, input int clear_step, input bit illegal);
      int ni;
      int nw;
      for (int s = 0; s < N_STEPS; s++) begin
         ni = (s == 0 && bp > 0) ? bp : (mode != 0 ? int'($urandom_range(0, 3)) : 0);
         nw = (mode != 0) ? int'($urandom_range(0, 3)) : 0;
         if (illegal && s == 3 && nw == 0) nw = 1;
         for (int k = 0; k < ni; k++) begin
            chk("issue_valid", vec_t'(valid_o), vec_t'(1));
            chk("issue_step", vec_t'(step_o), vec_t'(s));
            ready_i = 1'b0;
            done_i  = 1'($urandom_range(0, 1));
            idle_cycle();
         end
         chk("issue_valid", vec_t'(valid_o), vec_t'(1));
         chk("issue_step", vec_t'(step_o), vec_t'(s));
         ready_i = 1'b1;
         done_i  = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         op(1'b0, 0, '0, illegal && s == 2);
         ready_i = 1'b0;
         done_i  = 1'b0;
         for (int k = 0; k < nw; k++) begin
            chk("wait_valid", vec_t'(valid_o), '0);
            chk("wait_busy", vec_t'(busy_o), vec_t'(1));
            ready_i = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (illegal && s == 3 && k == 0) op(1'b1, $urandom_range(0, N_REG - 1), $urandom, 1'b0);
            else idle_cycle();
         end
         chk("wait_valid", vec_t'(valid_o), '0);
         if (s == clear_step) begin
            do_clear();
            return;
         end
         ready_i = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         done_i  = 1'b1;
         idle_cycle();
         done_i  = 1'b0;
         ready_i = 1'b0;
         if (s == N_STEPS - 1) begin
            m_idle = 1'b1;
            m_mask = '0;
            chk("end_busy", vec_t'(busy_o), '0);
            chk("end_fd", vec_t'(frame_done_o), vec_t'(1));
         end
      end
      idle_cycle();
      chk("fd_once", vec_t'(frame_done_o), '0);
      chk("queue_drained", vec_t'(exp_q.size() + fd_q.size()), '0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      vec_t v;
      rst_i       = 1'b1;
      test_mode_i = 1'b0;
      wr_en_i     = 1'b0;
      wr_idx_i    = '0;
      wr_data_i   = '0;
      start_i     = 1'b0;
      clear_i     = 1'b0;
      ready_i     = 1'b0;
      done_i      = 1'b0;
      m_idle      = 1'b1;
      m_mask      = '0;
      m_err       = 1'b0;
      for (int i = 0; i < N_REG; i++) m_buf[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;

      // reset state
      chk("rst_spikes", spikes_o, '0);
      chk("rst_valid", vec_t'(valid_o), '0);
      chk("rst_busy", vec_t'(busy_o), '0);
      chk("rst_step", vec_t'(step_o), '0);
      chk("rst_fd", vec_t'(frame_done_o), '0);
      chk("rst_err", vec_t'(err_o), '0);

      // full frame, fixed data, minimum step time
      for (int i = 0; i < N_REG; i++) op(1'b1, i, 32'hA5A5_0000 + 32'(i), 1'b0);
      op(1'b0, 0, '0, 1'b1);
      v = spikes_o;
      chk("word0", vec_t'(v[31:0]), vec_t'(32'hA5A5_0000));
      chk("last_word", vec_t'(v[783:768]), vec_t'(16'h0018));
      run_frame(0, 0, -1, 1'b0);

      // incomplete load rejected, then recovery through clear
      reload(1'b1);
      op(1'b0, 0, '0, 1'b1);
      op(1'b1, N_REG - 1, $urandom, 1'b0);
      do_clear();
      reload(1'b0);
      op(1'b0, 0, '0, 1'b1);
      run_frame(1, 0, -1, 1'b0);

      // backpressure: ready low for 10 cycles on the first step
      reload(1'b0);
      op(1'b0, 0, '0, 1'b1);
      run_frame(1, 10, -1, 1'b0);

      // illegal accesses: out-of-range index, write in WAIT, start in ISSUE
      op(1'b1, N_REG, $urandom, 1'b0);
      op(1'b1, $urandom_range(N_REG, 31), $urandom, 1'b0);
      reload(1'b0);
      op(1'b0, 0, '0, 1'b1);
      run_frame(1, 0, -1, 1'b1);
      do_clear();

      // abort in WAIT at step 7; no frame_done may follow
      reload(1'b0);
      op(1'b0, 0, '0, 1'b1);
      run_frame(1, 0, 7, 1'b0);
      repeat (5) idle_cycle();

      // final word written in the same cycle as start
      reload(1'b1);
      op(1'b1, N_REG - 1, $urandom, 1'b1);
      op(1'b0, 0, '0, 1'b1);
      run_frame(1, 0, -1, 1'b0);
      do_clear();

      // randomized frames
      repeat (4) begin
         reload(1'b0);
         op(1'b0, 0, '0, 1'b1);
         run_frame(1, 0, -1, 1'b0);
      end

      repeat (3) idle_cycle();
      chk("final_drained", vec_t'(exp_q.size() + fd_q.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
